skolem_sweep_ctrl: RTL and testbench
====================================

# skolem_sweep_ctrl

Sequential exhaustive-sweep controller for a combinational Skolem-function netlist with NX inputs and one output. On a start request it drives every input vector 0..2^NX-1 in ascending order into the netlist under test. For each vector it waits a fixed settle latency, then samples the netlist output and an externally evaluated specification-check bit. It accumulates violation and one-counts and reports pass/fail with a start/busy/done handshake. It sits beside the synthesized Skolem modules in the validation harness, one instance per function under test.

## Interface
- NX, 6: number of Skolem inputs swept (1..16)
- LAT, 1: cycles each vector is held before sampling (>=1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- abort  in  1  terminate a running sweep; no done pulse
- x_out  out  NX  current input vector to netlist; bit k drives input i_k
- y_in  in  1  netlist output for x_out
- spec_ok_in  in  1  spec formula F(x_out, y_in) evaluated externally; 1 = satisfied
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- pass  out  1  last completed sweep had zero violations
- fail_cnt  out  NX+1  number of vectors with spec_ok_in=0
- ones_cnt  out  NX+1  number of vectors with y_in=1
- first_fail  out  NX  lowest vector with spec_ok_in=0
- first_fail_vld  out  1  first_fail holds a valid vector

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1: x_out<=0, wcnt<=0, fail_cnt/ones_cnt/first_fail/first_fail_vld/pass<=0, go to WAIT.
- WAIT: hold x_out. If wcnt==LAT-1, go to SAMPLE; otherwise wcnt++.
- SAMPLE: ones_cnt += y_in and fail_cnt += ~spec_ok_in. If spec_ok_in=0 and first_fail_vld=0, then first_fail<=x_out and first_fail_vld<=1.
- SAMPLE, next step: if x_out==all ones, go to DONE; else x_out++, wcnt<=0, go to WAIT.
- DONE: pass<=(fail_cnt==0), go to IDLE.
- Counters are NX+1 bits wide, so 2^NX is representable and they never wrap.
- Results hold in IDLE until the next accepted start.
- abort=1 in WAIT or SAMPLE: go to IDLE next cycle with pass=0. The counters freeze at their partial values. The SAMPLE update in the abort cycle is discarded.
- abort has priority over the SAMPLE to DONE transition. abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored. start and abort together in IDLE: start wins.
- y_in and spec_ok_in are ignored outside SAMPLE.

## Timing
- busy=1 exactly in WAIT and SAMPLE. done=1 exactly in DONE.
- Reset: state=IDLE; x_out=0, busy=0, done=0, pass=0, fail_cnt=0, ones_cnt=0, first_fail=0, first_fail_vld=0, wcnt=0.
- rst mid-sweep overrides everything: same values next cycle, no done pulse.
- start sampled at edge 0: busy from cycle 1.
- Each vector is held LAT+1 cycles: LAT in WAIT, 1 in SAMPLE.
- Vector n sampled in cycle (n+1)(LAT+1).
- done in cycle 2^NX*(LAT+1)+1. pass is valid from the cycle after done.
- Back-to-back: start in the first IDLE cycle after DONE is accepted.

## Test plan
- Model y = ~x[5] & ~(x[3]&x[4]&(x[0]^x[1]^x[2])), spec_ok=1, NX=6, LAT=1, pulse start -> done at cycle 129, ones_cnt=28, fail_cnt=0, pass=1, first_fail_vld=0.
- Same run with spec_ok = ~(x_out==6'd37 | x_out==6'd50) -> fail_cnt=2, first_fail=37, first_fail_vld=1, pass=0.
- LAT=3, NX=6, y=1 -> x_out constant 4 cycles per vector, done at cycle 257, ones_cnt=64 (bit 6 set).
- abort in SAMPLE for vector 10 -> busy=0 next cycle, no done pulse, ones_cnt/fail_cnt reflect vectors 0..9 only, pass=0. Then start -> full sweep with counters cleared.
- rst asserted in WAIT of vector 20 -> all outputs 0 next cycle. start pulsed every cycle during a sweep -> ignored, done still at cycle 129.
- NX=1, LAT=1, y=x[0], spec_ok=0 -> done at cycle 5, fail_cnt=2, first_fail=0, ones_cnt=1.

Source files
------------

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive-sweep controller: walks every NX-bit input vector through a Skolem
// netlist, samples its output and an external spec-check bit, and tallies results.
module skolem_sweep_ctrl #(
    parameter int NX  = 6,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [NX-1:0] x_out,
    input  logic          y_in,
    input  logic          spec_ok_in,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [NX:0]   fail_cnt,
    output logic [NX:0]   ones_cnt,
    output logic [NX-1:0] first_fail,
    output logic          first_fail_vld
);

    localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [WW-1:0] r_wcnt;
    logic [NX-1:0] r_x;
    logic [NX:0]   r_fail;
    logic [NX:0]   r_ones;
    logic [NX-1:0] r_ff;
    logic          r_ffv;
    logic          r_pass;
    logic          w_last_vec;
    logic          w_wait_end;

    assign w_last_vec = &r_x;
    assign w_wait_end = (r_wcnt == WLAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_WAIT;
            S_WAIT: begin
                if (abort)           w_state_next = S_IDLE;
                else if (w_wait_end) w_state_next = S_SAMPLE;
            end
            // abort outranks the final-vector exit to DONE
            S_SAMPLE: begin
                if (abort)           w_state_next = S_IDLE;
                else if (w_last_vec) w_state_next = S_DONE;
                else                 w_state_next = S_WAIT;
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_x     <= '0;
            r_fail  <= '0;
            r_ones  <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wcnt <= '0;
                        r_x    <= '0;
                        r_fail <= '0;
                        r_ones <= '0;
                        r_ff   <= '0;
                        r_ffv  <= 1'b0;
                        r_pass <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (abort)            r_pass <= 1'b0;
                    else if (!w_wait_end) r_wcnt <= r_wcnt + 1'b1;
                end
                S_SAMPLE: begin
                    // Sample taken in an abort cycle is dropped; partial counts stay.
                    if (abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        r_ones <= r_ones + (NX+1)'(y_in);
                        r_fail <= r_fail + (NX+1)'(!spec_ok_in);
                        if (!spec_ok_in && !r_ffv) begin
                            r_ff  <= r_x;
                            r_ffv <= 1'b1;
                        end
                        if (!w_last_vec) begin
                            r_x    <= r_x + 1'b1;
                            r_wcnt <= '0;
                        end
                    end
                end
                S_DONE:  r_pass <= (r_fail == '0);
                default: ;
            endcase
        end
    end

    assign x_out          = r_x;
    assign busy           = (r_state == S_WAIT) || (r_state == S_SAMPLE);
    assign done           = (r_state == S_DONE);
    assign pass           = r_pass;
    assign fail_cnt       = r_fail;
    assign ones_cnt       = r_ones;
    assign first_fail     = r_ff;
    assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: table of full/aborted/reset sweeps on NX=6 LAT=1,
// plus hand-written LAT=3 and NX=1 sweeps. Netlist behaviour comes from truth tables.
module tb_skolem_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance 0: NX=6, LAT=1
    logic        s0 = 1'b0, a0 = 1'b0;
    logic [5:0]  x0, ff0;
    logic        y0, k0, busy0, done0, pass0, ffv0;
    logic [6:0]  fc0, oc0;
    logic [63:0] ytab0 = '0, stab0 = '1;
    assign y0 = ytab0[x0];
    assign k0 = stab0[x0];

    skolem_sweep_ctrl #(.NX(6), .LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(s0), .abort(a0), .x_out(x0), .y_in(y0),
        .spec_ok_in(k0), .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0),
        .ones_cnt(oc0), .first_fail(ff0), .first_fail_vld(ffv0));

    // instance 1: NX=6, LAT=3, y=1, spec always satisfied
    logic        s1 = 1'b0, a1 = 1'b0, y1 = 1'b1, k1 = 1'b1;
    logic [5:0]  x1, ff1;
    logic        busy1, done1, pass1, ffv1;
    logic [6:0]  fc1, oc1;

    skolem_sweep_ctrl #(.NX(6), .LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(s1), .abort(a1), .x_out(x1), .y_in(y1),
        .spec_ok_in(k1), .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1),
        .ones_cnt(oc1), .first_fail(ff1), .first_fail_vld(ffv1));

    // instance 2: NX=1, LAT=1, y=x[0], spec never satisfied
    logic        s2 = 1'b0, a2 = 1'b0, k2 = 1'b0;
    logic [0:0]  x2, ff2;
    logic        y2, busy2, done2, pass2, ffv2;
    logic [1:0]  fc2, oc2;
    assign y2 = x2[0];

    skolem_sweep_ctrl #(.NX(1), .LAT(1)) u2 (
        .clk(clk), .rst(rst), .start(s2), .abort(a2), .x_out(x2), .y_in(y2),
        .spec_ok_in(k2), .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fc2),
        .ones_cnt(oc2), .first_fail(ff2), .first_fail_vld(ffv2));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] yt;
        logic [63:0] st;
        int          kill;   // cycle in which abort/rst is raised, -1 = none
        bit          krst;
        bit          spam;   // hold start high for the whole sweep
        logic [6:0]  eo;
        logic [6:0]  ef;
        logic [5:0]  eff;
        logic        effv;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: tally the first nv vectors of the truth tables.
    task automatic model(input logic [63:0] yt, input logic [63:0] st, input int nv,
                         output logic [6:0] eo, output logic [6:0] ef,
                         output logic [5:0] eff, output logic effv);
        eo = '0; ef = '0; eff = '0; effv = 1'b0;
        for (int i = 0; i < nv; i++) begin
            if (yt[i]) eo++;
            if (!st[i]) begin
                ef++;
                if (!effv) begin
                    eff  = 6'(i);
                    effv = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [63:0] paper_y();
        logic [63:0] t;
        logic [5:0]  v;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            t[i] = ~v[5] & ~(v[3] & v[4] & (v[0] ^ v[1] ^ v[2]));
        end
        return t;
    endfunction

    // Called at a negedge; start is raised in that very cycle.
    task automatic run0(input int idx, input vec_t v);
        int c, done_c, bad_c;
        ytab0 = v.yt;
        stab0 = v.st;
        s0 = 1'b1;
        @(posedge clk);
        c = 0; done_c = -1; bad_c = -1;
        while (c < 400) begin
            @(negedge clk);
            c++;
            if (!v.spam) s0 = 1'b0;
            a0 = 1'b0;
            rst = 1'b0;
            if (done0) begin
                done_c = c;
                s0 = 1'b0;
                break;
            end
            if (c == v.kill + 1) break;
            if ((!busy0 || x0 != 6'((c - 1) / 2)) && bad_c < 0) bad_c = c;
            if (c == v.kill) begin
                if (v.krst) rst = 1'b1;
                else        a0 = 1'b1;
            end
        end
        s0 = 1'b0;
        chk("x_sequence_first_bad_cycle", 64'(bad_c), 64'hFFFF_FFFF_FFFF_FFFF);
        if (v.kill < 0) begin
            chk("done_cycle", 64'(done_c), 64'd129);
            @(negedge clk);
            chk("pass", pass0, v.ef == 0);
            chk("ones_cnt", oc0, v.eo);
            chk("fail_cnt", fc0, v.ef);
            chk("first_fail", ff0, v.eff);
            chk("first_fail_vld", ffv0, v.effv);
            chk("idle_busy_done", {busy0, done0}, 2'b00);
        end else if (v.krst) begin
            chk("rst_no_done", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
            chk("rst_outputs", {x0, busy0, done0, pass0, fc0, oc0, ff0, ffv0}, '0);
        end else begin
            chk("abort_no_done", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
            chk("abort_busy", busy0, 1'b0);
            chk("abort_pass", pass0, 1'b0);
            chk("abort_ones_cnt", oc0, v.eo);
            chk("abort_fail_cnt", fc0, v.ef);
            chk("abort_first_fail", {ffv0, ff0}, {v.effv, v.eff});
            bad_c = 0;
            repeat (4) begin
                @(negedge clk);
                if (done0 || busy0) bad_c++;
            end
            chk("abort_stays_idle", 64'(bad_c), 64'd0);
        end
        $display("sweep %0d: kill=%0d ones=%0d fails=%0d first=%0d vld=%0b pass=%0b done_cycle=%0d",
                 idx, v.kill, oc0, fc0, ff0, ffv0, pass0, done_c);
    endtask

    initial begin
        int c, done_c, bad_c, nv;
        logic [63:0] py;

        py = paper_y();
        for (int i = 0; i < 12; i++) begin
            tbl[i].yt = {$urandom, $urandom};
            tbl[i].st = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            tbl[i].kill = -1; tbl[i].krst = 1'b0; tbl[i].spam = 1'b0;
        end
        tbl[0] = '{py, '1, -1, 1'b0, 1'b0, 7'd28, 7'd0, 6'd0, 1'b0};
        tbl[1] = '{py, ~((64'd1 << 37) | (64'd1 << 50)), -1, 1'b0, 1'b0, 7'd28, 7'd2, 6'd37, 1'b1};
        tbl[2] = '{py, '1, -1, 1'b0, 1'b1, 7'd28, 7'd0, 6'd0, 1'b0};
        tbl[3] = '{'1, ~(64'd1 << 63), -1, 1'b0, 1'b0, 7'd64, 7'd1, 6'd63, 1'b1};
        tbl[4] = '{'0, ~64'd1, -1, 1'b0, 1'b0, 7'd0, 7'd1, 6'd0, 1'b1};
        tbl[6] = '{py, '1, -1, 1'b0, 1'b0, 7'd28, 7'd0, 6'd0, 1'b0};
        tbl[5].kill = 22;                        // SAMPLE of vector 10
        tbl[7].kill = 41; tbl[7].krst = 1'b1;    // WAIT of vector 20
        tbl[8].kill = 128;                       // SAMPLE of the last vector
        tbl[9].kill = int'($urandom_range(1, 127));
        tbl[11].st = '1;
        foreach (tbl[i]) begin
            if (i == 5 || i >= 7) begin
                nv = (tbl[i].kill < 0) ? 64 : (tbl[i].kill - 1) / 2;
                model(tbl[i].yt, tbl[i].st, nv, tbl[i].eo, tbl[i].ef, tbl[i].eff, tbl[i].effv);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_u0", {x0, busy0, done0, pass0, fc0, oc0, ff0, ffv0}, '0);
        chk("reset_u1", {x1, busy1, done1, pass1, fc1, oc1, ff1, ffv1}, '0);
        chk("reset_u2", {x2, busy2, done2, pass2, fc2, oc2, ff2, ffv2}, '0);

        for (int i = 0; i < 12; i++) run0(i, tbl[i]);

        // LAT=3: each vector held 4 cycles, done at 2^6*4+1
        @(negedge clk);
        s1 = 1'b1;
        @(posedge clk);
        c = 0; done_c = -1; bad_c = -1;
        while (c < 400) begin
            @(negedge clk);
            c++;
            s1 = 1'b0;
            if (done1) begin done_c = c; break; end
            if ((!busy1 || x1 != 6'((c - 1) / 4)) && bad_c < 0) bad_c = c;
        end
        chk("lat3_x_sequence_first_bad_cycle", 64'(bad_c), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lat3_done_cycle", 64'(done_c), 64'd257);
        @(negedge clk);
        chk("lat3_results", {pass1, fc1, oc1, ffv1}, {1'b1, 7'd0, 7'd64, 1'b0});
        $display("sweep lat3: ones=%0d fails=%0d pass=%0b done_cycle=%0d", oc1, fc1, pass1, done_c);

        // NX=1: two vectors, both failing, done at cycle 5
        s2 = 1'b1;
        @(posedge clk);
        c = 0; done_c = -1; bad_c = -1;
        while (c < 50) begin
            @(negedge clk);
            c++;
            s2 = 1'b0;
            if (done2) begin done_c = c; break; end
            if ((!busy2 || x2 != 1'((c - 1) / 2)) && bad_c < 0) bad_c = c;
        end
        chk("nx1_x_sequence_first_bad_cycle", 64'(bad_c), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("nx1_done_cycle", 64'(done_c), 64'd5);
        @(negedge clk);
        chk("nx1_results", {pass2, fc2, oc2, ff2, ffv2}, {1'b0, 2'd2, 2'd1, 1'b0, 1'b1});
        $display("sweep nx1: ones=%0d fails=%0d first=%0d vld=%0b pass=%0b done_cycle=%0d",
                 oc2, fc2, ff2, ffv2, pass2, done_c);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
